// File: rtl/alt_vipvfr131_common_control_packet_scheduler_pkg.sv
// Shared definitions for the control-packet scheduler.
//   sched_state_t   : scheduler FSM state encoding
//   IL_*_BIT        : bit positions inside the 4-bit interlace nibble
//   FIELD_F0/F1     : field identifiers
//   field_lines()   : lines carried by one frame/field of a configuration
//   enc_ilace()     : interlace nibble handed to the encoder for a field
//   cfg_ok()        : acceptance rule for a committed configuration
package alt_vipvfr131_common_control_packet_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_VIDEO    = 2'd2,
    ST_BOUNDARY = 2'd3
  } sched_state_t;

  localparam int unsigned IL_ENABLE_BIT = 3;
  localparam int unsigned IL_FIELD_BIT  = 2;

  localparam logic FIELD_F0 = 1'b0;
  localparam logic FIELD_F1 = 1'b1;

  // F0 carries the extra line when an interlaced height is odd.
  function automatic logic [15:0] field_lines(input logic [15:0] height,
                                              input logic [3:0]  ilace,
                                              input logic        field);
    logic [16:0] h_up;
    logic [15:0] res;
    h_up = {1'b0, height} + 17'd1;
    if (!ilace[IL_ENABLE_BIT])
      res = height;
    else if (field == FIELD_F0)
      res = h_up[16:1];
    else
      res = {1'b0, height[15:1]};
    return res;
  endfunction

  function automatic logic [3:0] enc_ilace(input logic [3:0] ilace,
                                           input logic       field);
    logic [3:0] res;
    res = ilace;
    if (ilace[IL_ENABLE_BIT]) begin
      res[IL_ENABLE_BIT] = 1'b1;
      res[IL_FIELD_BIT]  = field;
    end
    return res;
  endfunction

  function automatic logic cfg_ok(input logic [15:0] width,
                                  input logic [15:0] height,
                                  input logic [3:0]  ilace,
                                  input int unsigned ppb);
    logic [15:0] rem;
    rem = width % 16'(ppb);
    return (width != '0) && (height != '0) && (rem == '0) &&
           !(ilace[IL_ENABLE_BIT] && (height < 16'd2));
  endfunction

endpackage

// File: rtl/alt_vipvfr131_common_frame_position_counter.sv
// Column/line position tracker for one frame or field.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clear    : hold both counters at zero
//   i_beat     : one accepted beat (ignored while i_clear)
//   i_width    : frame width in pixels (multiple of PIXELS_PER_BEAT)
//   i_lines    : lines in the current frame/field (>= 1)
//   o_last     : current position is the final beat of the frame/field
module alt_vipvfr131_common_frame_position_counter #(
  parameter int unsigned PIXELS_PER_BEAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_beat,
  input  logic [15:0] i_width,
  input  logic [15:0] i_lines,
  output logic        o_last
);

  localparam logic [15:0] STEP = 16'(PIXELS_PER_BEAT);

  logic [15:0] r_col;
  logic [15:0] r_line;
  logic        w_col_end;
  logic        w_line_end;

  assign w_col_end  = (r_col  == i_width - STEP);
  assign w_line_end = (r_line == i_lines - 16'd1);
  assign o_last     = w_col_end & w_line_end;

  // Both counters wrap to zero on the last beat, so they never pass
  // width-STEP or lines-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= '0;
      r_line <= '0;
    end else if (i_clear) begin
      r_col  <= '0;
      r_line <= '0;
    end else if (i_beat) begin
      if (w_col_end) begin
        r_col  <= '0;
        r_line <= w_line_end ? '0 : r_line + 16'd1;
      end else begin
        r_col  <= r_col + STEP;
      end
    end
  end

endmodule

// File: rtl/alt_vipvfr131_common_control_packet_scheduler.sv
// Schedules encoder control packets and marks end of each frame/field.
//   clk, rst_n            : clock, asynchronous active-low reset
//   ctrl_go               : level, 1 = keep running frames
//   cfg_width/height/interlaced, cfg_commit : pending-configuration load
//   enc_vip_ctrl_busy     : encoder busy
//   enc_vip_ctrl_send     : control-packet request (SEND and not busy)
//   enc_width/height/interlaced : values for the encoder, frozen per frame
//   vid_valid, vid_ready  : monitored encoder sink handshake
//   end_of_video          : last accepted beat of the frame/field
//   running, frame_count, cfg_pending, cfg_error : status
module alt_vipvfr131_common_control_packet_scheduler
  import alt_vipvfr131_common_control_packet_scheduler_pkg::*;
#(
  parameter int unsigned PIXELS_PER_BEAT   = 1,
  parameter int unsigned FRAME_COUNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ctrl_go,
  input  logic [15:0]                  cfg_width,
  input  logic [15:0]                  cfg_height,
  input  logic [3:0]                   cfg_interlaced,
  input  logic                         cfg_commit,
  input  logic                         enc_vip_ctrl_busy,
  output logic                         enc_vip_ctrl_send,
  output logic [15:0]                  enc_width,
  output logic [15:0]                  enc_height,
  output logic [3:0]                   enc_interlaced,
  input  logic                         vid_valid,
  input  logic                         vid_ready,
  output logic                         end_of_video,
  output logic                         running,
  output logic [FRAME_COUNT_WIDTH-1:0] frame_count,
  output logic                         cfg_pending,
  output logic                         cfg_error
);

  sched_state_t r_state;

  logic [15:0] r_act_width;
  logic [15:0] r_act_height;
  logic [3:0]  r_act_ilace;
  logic        r_act_valid;
  logic [15:0] r_pend_width;
  logic [15:0] r_pend_height;
  logic [3:0]  r_pend_ilace;
  logic        r_pend_valid;
  logic        r_field;
  logic        r_cfg_error;

  logic [15:0]                  r_enc_width;
  logic [15:0]                  r_enc_height;
  logic [3:0]                   r_enc_ilace;
  logic [FRAME_COUNT_WIDTH-1:0] r_frame_count;

  logic        w_commit_ok;
  logic        w_commit_bad;
  logic        w_apply;
  logic [15:0] w_src_width;
  logic [15:0] w_src_height;
  logic [3:0]  w_src_ilace;
  logic [15:0] w_eff_width;
  logic [15:0] w_eff_height;
  logic [3:0]  w_eff_ilace;
  logic        w_eff_valid;
  logic        w_eff_field;
  logic        w_start;
  logic        w_beat;
  logic        w_last;
  logic        w_eov;

  assign w_commit_ok  = cfg_commit &&
                        cfg_ok(cfg_width, cfg_height, cfg_interlaced, PIXELS_PER_BEAT);
  assign w_commit_bad = cfg_commit && !w_commit_ok;

  // w_eff_* is the active configuration as it stands after this edge.
  // Both the active registers and the encoder values are loaded from it,
  // so a frame started in the same cycle a configuration is applied
  // already carries the new values. In IDLE a fresh valid commit takes
  // effect directly; a leftover pending configuration is applied too.
  always_comb begin
    w_apply      = 1'b0;
    w_src_width  = r_pend_width;
    w_src_height = r_pend_height;
    w_src_ilace  = r_pend_ilace;
    case (r_state)
      ST_IDLE: begin
        if (w_commit_ok) begin
          w_apply      = 1'b1;
          w_src_width  = cfg_width;
          w_src_height = cfg_height;
          w_src_ilace  = cfg_interlaced;
        end else if (r_pend_valid) begin
          w_apply = 1'b1;
        end
      end
      ST_BOUNDARY: w_apply = r_pend_valid;
      default: ;
    endcase

    w_eff_width  = w_apply ? w_src_width  : r_act_width;
    w_eff_height = w_apply ? w_src_height : r_act_height;
    w_eff_ilace  = w_apply ? w_src_ilace  : r_act_ilace;
    w_eff_valid  = w_apply | r_act_valid;

    w_eff_field = r_field;
    if (w_apply)
      w_eff_field = FIELD_F0;
    else if ((r_state == ST_BOUNDARY) && r_act_ilace[IL_ENABLE_BIT])
      w_eff_field = ~r_field;
  end

  assign w_start = ((r_state == ST_IDLE) || (r_state == ST_BOUNDARY)) &&
                   ctrl_go && w_eff_valid;
  assign w_beat  = vid_valid & vid_ready;
  assign w_eov   = (r_state == ST_VIDEO) & w_beat & w_last;

  // Configuration registers. A valid commit outside IDLE always lands in
  // pending; being written after the apply-clear, a commit in the
  // BOUNDARY cycle survives for the next boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_width   <= '0;
      r_act_height  <= '0;
      r_act_ilace   <= '0;
      r_act_valid   <= 1'b0;
      r_pend_width  <= '0;
      r_pend_height <= '0;
      r_pend_ilace  <= '0;
      r_pend_valid  <= 1'b0;
      r_field       <= FIELD_F0;
      r_cfg_error   <= 1'b0;
    end else begin
      r_act_width  <= w_eff_width;
      r_act_height <= w_eff_height;
      r_act_ilace  <= w_eff_ilace;
      r_act_valid  <= w_eff_valid;
      r_field      <= w_eff_field;
      if (w_apply)
        r_pend_valid <= 1'b0;
      if (w_commit_ok && (r_state != ST_IDLE)) begin
        r_pend_width  <= cfg_width;
        r_pend_height <= cfg_height;
        r_pend_ilace  <= cfg_interlaced;
        r_pend_valid  <= 1'b1;
      end
      if (w_commit_ok)
        r_cfg_error <= 1'b0;
      else if (w_commit_bad)
        r_cfg_error <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_enc_width   <= '0;
      r_enc_height  <= '0;
      r_enc_ilace   <= '0;
      r_frame_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_BOUNDARY: begin
          if (w_start) begin
            r_state      <= ST_SEND;
            r_enc_width  <= w_eff_width;
            r_enc_height <= field_lines(w_eff_height, w_eff_ilace, w_eff_field);
            r_enc_ilace  <= enc_ilace(w_eff_ilace, w_eff_field);
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (!enc_vip_ctrl_busy)
            r_state <= ST_VIDEO;
        end
        ST_VIDEO: begin
          if (w_eov) begin
            r_state       <= ST_BOUNDARY;
            r_frame_count <= r_frame_count + FRAME_COUNT_WIDTH'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // enc_height equals the line count of the frame/field in both modes.
  alt_vipvfr131_common_frame_position_counter #(
    .PIXELS_PER_BEAT(PIXELS_PER_BEAT)
  ) u_pos (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clear(r_state != ST_VIDEO),
    .i_beat (w_beat),
    .i_width(r_enc_width),
    .i_lines(r_enc_height),
    .o_last (w_last)
  );

  assign enc_vip_ctrl_send = (r_state == ST_SEND) && !enc_vip_ctrl_busy;
  assign enc_width         = r_enc_width;
  assign enc_height        = r_enc_height;
  assign enc_interlaced    = r_enc_ilace;
  assign end_of_video      = w_eov;
  assign running           = (r_state != ST_IDLE);
  assign frame_count       = r_frame_count;
  assign cfg_pending       = r_pend_valid;
  assign cfg_error         = r_cfg_error;

endmodule

// File: doc/alt_vipvfr131_common_control_packet_scheduler.md
ALT_VIPVFR131_COMMON_CONTROL_PACKET_SCHEDULER -- requirements
Module: alt_vipvfr131_common_control_packet_scheduler

Interface
REQ-001 SHALL have parameter PIXELS_PER_BEAT, default 1, meaning pixels carried per accepted video beat.
REQ-002 SHALL have parameter FRAME_COUNT_WIDTH, default 16, meaning the width of the frame_count output.
REQ-003 SHALL have one clock and an asynchronous, active-low reset. The ports SHALL be clk (in, 1, rising-edge clock) and rst_n (in, 1, asynchronous active-low reset).
REQ-004 SHALL have the following configuration and control ports:
- ctrl_go (in, 1): level input; 1 = run frames.
- cfg_width (in, 16): pending frame width in pixels.
- cfg_height (in, 16): pending frame height in lines.
- cfg_interlaced (in, 4): pending interlace nibble. Bit3 = interlaced.
- cfg_commit (in, 1): single-cycle pulse that latches the cfg_* inputs into pending.
REQ-005 SHALL have the following encoder-facing ports:
- enc_vip_ctrl_busy (in, 1): encoder busy flag.
- enc_vip_ctrl_send (out, 1): control-packet request pulse.
- enc_width (out, 16), enc_height (out, 16), enc_interlaced (out, 4): values handed to the encoder.
- vid_valid (in, 1), vid_ready (in, 1): monitor of the encoder sink handshake.
- end_of_video (out, 1): marks the last beat of the current frame or field.
REQ-006 SHALL have the following status ports:
- running (out, 1): 1 in any state other than IDLE.
- frame_count (out, FRAME_COUNT_WIDTH): completed frames/fields.
- cfg_pending (out, 1): a committed configuration is waiting to be applied.
- cfg_error (out, 1): sticky flag for a rejected commit.

Function
REQ-007 SHALL implement the FSM states IDLE, SEND, VIDEO and BOUNDARY.
REQ-008 In IDLE, SHALL move to SEND when ctrl_go=1 and a valid active configuration exists. Otherwise it stays in IDLE.
REQ-009 In SEND, SHALL drive enc_vip_ctrl_send=1 combinationally while enc_vip_ctrl_busy=0, and SHALL move to VIDEO on that same cycle. While busy=1 it SHALL hold in SEND with send=0.
REQ-010 SHALL keep enc_width, enc_height and enc_interlaced stable from entry to SEND until exit from VIDEO.
REQ-011 In VIDEO, SHALL count accepted beats (vid_valid & vid_ready) with a column counter stepping by PIXELS_PER_BEAT and a line counter.
REQ-012 SHALL assert end_of_video combinationally only on the accepted beat where column = width-PIXELS_PER_BEAT and line = field_lines-1. It SHALL never assert end_of_video outside VIDEO.
REQ-013 The end_of_video beat SHALL move the FSM to BOUNDARY and increment frame_count; frame_count wraps modulo 2^FRAME_COUNT_WIDTH.
REQ-014 BOUNDARY SHALL last exactly one cycle and do the following:
- Copy pending to active if cfg_pending=1, then clear cfg_pending.
- Update the field bit.
- Go to SEND if ctrl_go=1, else to IDLE.
REQ-015 Deasserting ctrl_go mid-frame SHALL NOT truncate the frame; the stop takes effect at BOUNDARY.
REQ-016 Progressive mode (interlaced bit3=0): field_lines = height, enc_height = height, and enc_interlaced = the active nibble.
REQ-017 Interlaced mode (bit3=1) SHALL alternate F0/F1 fields, starting at F0 after reset or after any configuration change:
- F0: field_lines = (height+1)>>1.
- F1: field_lines = height>>1.
- enc_height = field_lines.
- enc_interlaced = {1, field, active[1:0]}.
REQ-018 cfg_commit with width=0, height=0, width not a multiple of PIXELS_PER_BEAT, or interlaced height<2 SHALL be rejected. Rejection sets cfg_error and leaves pending unchanged. A valid commit SHALL clear cfg_error.
REQ-019 Commit ordering SHALL be as follows:
- A second valid commit before BOUNDARY overwrites pending (last wins).
- A commit in the BOUNDARY cycle goes to pending and applies at the next BOUNDARY.
- A commit while IDLE applies on the following cycle.
REQ-020 The counters SHALL be 16 bits and SHALL never exceed width-PIXELS_PER_BEAT or field_lines-1.

Reset
REQ-021 rst_n low SHALL asynchronously force the following values, including in the middle of a frame; no partial frame resumes after reset:
- State IDLE.
- All outputs 0.
- Active and pending configuration 0; no valid active configuration.
- Counters 0 and field F0.

Structure
REQ-022 A shared package SHALL hold the FSM state encoding, the interlace nibble bit positions, and the F0/F1 constants.
REQ-023 One sub-module, alt_vipvfr131_common_frame_position_counter (column/line counters plus last-beat detect), SHALL be instantiated. All other logic SHALL stay flat.

Verification
REQ-024 Progressive 4x2 frame, PIXELS_PER_BEAT=1, go=1, busy=0: send pulses one cycle after commit; end_of_video asserts on beat 8 only; frame_count=1.
REQ-025 Interlaced 4x5 frame: the first field sends enc_height=3 and enc_interlaced=4'b1000; the next field sends enc_height=2 and enc_interlaced=4'b1100; end_of_video asserts on beats 12 and 8.
REQ-026 Commit 8x2 mid-frame while 4x2 is active: the current frame still ends at beat 8; the next SEND carries width 8; cfg_pending falls at BOUNDARY.
REQ-027 Hold busy=1 for 5 cycles in SEND: send stays 0 throughout, then pulses exactly once; vid_valid held low delays end_of_video without miscounting.
REQ-028 Commit width 3 with PIXELS_PER_BEAT=2: cfg_error=1 and the active configuration is unchanged. Then assert rst_n=0 mid-frame: all outputs are 0 immediately and the FSM sits in IDLE.
